// File: rtl/ring_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ring_sequencer
// Purpose  : Rotating-pattern sequencer. The pattern is either a one-hot
//            ring or a Johnson (twisted-ring) count. It supports:
//              - either rotation direction
//              - an enable with a prescale divider
//              - parallel load
//              - self-correction of illegal patterns
//              - single-cycle WRAP / ERR pulses
// Ports    : CLK      - clock, rising edge
//            RST      - synchronous active-high reset
//            EN       - count enable (prescaler and pattern hold when low)
//            MODE     - 0 = one-hot ring, 1 = Johnson
//            DIR      - 0 = rotate toward MSB, 1 = rotate toward LSB
//            DIV      - advance once every DIV+1 enabled cycles
//            LOAD     - parallel load strobe
//            LOAD_VAL - value written to O on LOAD (stored verbatim)
//            O        - current pattern (registered)
//            WRAP     - pulse: pattern returned home by a legal advance
//            ERR      - pulse: illegal pattern replaced by home on advance
// Revision : 1.0 - initial release
// ============================================================================
module ring_sequencer #(
  parameter int WIDTH = 4,
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             EN,
  input  logic             MODE,
  input  logic             DIR,
  input  logic [DIV_W-1:0] DIV,
  input  logic             LOAD,
  input  logic [WIDTH-1:0] LOAD_VAL,
  output logic [WIDTH-1:0] O,
  output logic             WRAP,
  output logic             ERR
);

  localparam logic [WIDTH-1:0] c_one   = WIDTH'(1);
  localparam logic [DIV_W-1:0] c_p_one = DIV_W'(1);

  logic [WIDTH-1:0] r_o;
  logic [DIV_W-1:0] r_p;
  logic             r_wrap;
  logic             r_err;

  logic [WIDTH-1:0] w_home;
  logic [WIDTH-1:0] w_rot;
  logic [WIDTH-1:0] w_inv;
  logic             w_ring_legal;
  logic             w_john_legal;
  logic             w_legal;
  logic             w_adv;

  // Home depends on the mode in effect right now, so a mode switch
  // followed by an advance lands on the new mode's home.
  assign w_home = MODE ? '0 : c_one;

  // One-hot: non-zero, and clearing the lowest set bit leaves nothing.
  assign w_ring_legal = (r_o != '0) && ((r_o & (r_o - c_one)) == '0);

  // Johnson: a run of ones anchored at bit0 has the form 2^k-1, so x & (x+1)
  // is zero. A run anchored at the MSB is the complement of such a value.
  // Together these two forms cover all 2*WIDTH Johnson states, including
  // all-zeros and all-ones.
  assign w_inv        = ~r_o;
  assign w_john_legal = ((r_o & (r_o + c_one)) == '0) ||
                        ((w_inv & (w_inv + c_one)) == '0);

  assign w_legal = MODE ? w_john_legal : w_ring_legal;

  // >= rather than == so that lowering DIV below the current count
  // advances at once instead of waiting for the counter to wrap.
  assign w_adv = EN && (r_p >= DIV);

  always_comb begin
    w_rot = r_o;
    case ({MODE, DIR})
      2'b00:   w_rot = {r_o[WIDTH-2:0], r_o[WIDTH-1]};
      2'b01:   w_rot = {r_o[0], r_o[WIDTH-1:1]};
      2'b10:   w_rot = {r_o[WIDTH-2:0], ~r_o[WIDTH-1]};
      default: w_rot = {~r_o[0], r_o[WIDTH-1:1]};
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_o    <= w_home;
      r_p    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (LOAD) begin
      r_o    <= LOAD_VAL;
      r_p    <= '0;
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end else if (w_adv) begin
      r_p <= '0;
      if (w_legal) begin
        r_o    <= w_rot;
        r_wrap <= (w_rot == w_home);
        r_err  <= 1'b0;
      end else begin
        r_o    <= w_home;
        r_wrap <= 1'b0;
        r_err  <= 1'b1;
      end
    end else begin
      if (EN) begin
        r_p <= r_p + c_p_one;
      end
      r_wrap <= 1'b0;
      r_err  <= 1'b0;
    end
  end

  assign O    = r_o;
  assign WRAP = r_wrap;
  assign ERR  = r_err;

endmodule
`default_nettype wire

// File: tb/tb_ring_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ring_sequencer
// Purpose  : Self-checking bench for ring_sequencer.
//            It drives three instances (WIDTH 4, 2 and 32) from shared
//            controls. Directed stimulus pushes hand-computed expectations
//            into a queue. A monitor pops and compares them one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ring_sequencer;

  logic        CLK;
  logic        RST;
  logic        EN;
  logic        MODE;
  logic        DIR;
  logic [7:0]  DIV;
  logic        LOAD;
  logic [3:0]  LV4;
  logic [1:0]  LV2;
  logic [31:0] LV32;
  logic [3:0]  O4;
  logic [1:0]  O2;
  logic [31:0] O32;
  logic        W4, E4, W2, E2, W32, E32;

  ring_sequencer #(.WIDTH(4), .DIV_W(8)) u_dut4 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIR(DIR), .DIV(DIV),
    .LOAD(LOAD), .LOAD_VAL(LV4), .O(O4), .WRAP(W4), .ERR(E4));

  ring_sequencer #(.WIDTH(2), .DIV_W(8)) u_dut2 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIR(DIR), .DIV(DIV),
    .LOAD(LOAD), .LOAD_VAL(LV2), .O(O2), .WRAP(W2), .ERR(E2));

  ring_sequencer #(.WIDTH(32), .DIV_W(8)) u_dut32 (
    .CLK(CLK), .RST(RST), .EN(EN), .MODE(MODE), .DIR(DIR), .DIV(DIV),
    .LOAD(LOAD), .LOAD_VAL(LV32), .O(O32), .WRAP(W32), .ERR(E32));

  typedef struct {
    int          dut;
    logic [31:0] o;
    logic        wrap;
    logic        err;
    string       nm;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Expectations pushed before a rising edge describe the state after it.
  task automatic push(input int d, input logic [31:0] o, input logic w,
                      input logic e, input string nm);
    exp_t x;
    x.dut = d; x.o = o; x.wrap = w; x.err = e; x.nm = nm;
    sb.push_back(x);
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // Expect a WIDTH=4 result for the coming edge, then let the edge pass.
  task automatic s4(input logic [3:0] o, input logic w, input logic e,
                    input string nm);
    push(4, {28'd0, o}, w, e, nm);
    step();
  endtask

  // Monitor: every output is registered, so each cycle is a presentation.
  always @(posedge CLK) begin
    #1;
    while (sb.size() > 0) begin
      exp_t x;
      logic [31:0] ao;
      logic aw, ae;
      x = sb.pop_front();
      case (x.dut)
        2:       begin ao = {30'd0, O2}; aw = W2;  ae = E2;  end
        32:      begin ao = O32;         aw = W32; ae = E32; end
        default: begin ao = {28'd0, O4}; aw = W4;  ae = E4;  end
      endcase
      n_cmp++;
      if (ao !== x.o || aw !== x.wrap || ae !== x.err) begin
        n_bad++;
        $display("FAIL %s (w%0d): got O=%h WRAP=%b ERR=%b, want O=%h WRAP=%b ERR=%b",
                 x.nm, x.dut, ao, aw, ae, x.o, x.wrap, x.err);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ones;
    logic [31:0] one32;
    ones  = '1;
    one32 = 32'd1;

    // Reset, with LOAD and EN also high: reset wins.
    RST = 1; EN = 1; MODE = 0; DIR = 0; DIV = 8'd0; LOAD = 1;
    LV4 = 4'b0110; LV2 = 2'b00; LV32 = 32'd0;
    s4(4'b0001, 0, 0, "rst_over_load");
    LOAD = 0;
    s4(4'b0001, 0, 0, "rst_home_ring");

    // Ring rotation toward MSB.
    RST = 0;
    s4(4'b0010, 0, 0, "ring_1");
    s4(4'b0100, 0, 0, "ring_2");
    s4(4'b1000, 0, 0, "ring_3");
    s4(4'b0001, 1, 0, "ring_wrap");
    s4(4'b0010, 0, 0, "ring_after_wrap");

    // Johnson, both directions.
    RST = 1; MODE = 1;
    s4(4'b0000, 0, 0, "rst_home_john");
    RST = 0;
    s4(4'b0001, 0, 0, "john_up_1");
    s4(4'b0011, 0, 0, "john_up_2");
    s4(4'b0111, 0, 0, "john_up_3");
    s4(4'b1111, 0, 0, "john_up_4");
    s4(4'b1110, 0, 0, "john_up_5");
    s4(4'b1100, 0, 0, "john_up_6");
    s4(4'b1000, 0, 0, "john_up_7");
    s4(4'b0000, 1, 0, "john_up_wrap");
    DIR = 1;
    s4(4'b1000, 0, 0, "john_dn_1");
    s4(4'b1100, 0, 0, "john_dn_2");
    s4(4'b1110, 0, 0, "john_dn_3");
    s4(4'b1111, 0, 0, "john_dn_4");
    s4(4'b0111, 0, 0, "john_dn_5");
    s4(4'b0011, 0, 0, "john_dn_6");
    s4(4'b0001, 0, 0, "john_dn_7");
    s4(4'b0000, 1, 0, "john_dn_wrap");

    // Prescale DIV=2: advance every third enabled cycle.
    RST = 1; MODE = 0; DIR = 0; DIV = 8'd2;
    s4(4'b0001, 0, 0, "rst_div2");
    RST = 0;
    s4(4'b0001, 0, 0, "div2_p1");
    s4(4'b0001, 0, 0, "div2_p2");
    s4(4'b0010, 0, 0, "div2_adv1");
    s4(4'b0010, 0, 0, "div2_p1b");
    s4(4'b0010, 0, 0, "div2_p2b");
    s4(4'b0100, 0, 0, "div2_adv2");
    s4(4'b0100, 0, 0, "div2_p1c");
    // Freeze with P=1 for five cycles.
    EN = 0;
    for (int i = 0; i < 5; i++) s4(4'b0100, 0, 0, "en_low_hold");
    EN = 1;
    s4(4'b0100, 0, 0, "en_resume_p2");
    s4(4'b1000, 0, 0, "en_resume_adv");

    // DIV 7 with P reaching 5, then DIV drops to 1.
    DIV = 8'd7;
    for (int i = 0; i < 5; i++) s4(4'b1000, 0, 0, "div7_count");
    DIV = 8'd1;
    s4(4'b0001, 1, 0, "div_lowered_adv");

    // Illegal load with A also true: load wins, then self-correct.
    DIV = 8'd0; LOAD = 1; LV4 = 4'b0110;
    s4(4'b0110, 0, 0, "load_illegal");
    LOAD = 0;
    s4(4'b0001, 0, 1, "err_correct");
    s4(4'b0010, 0, 0, "err_pulse_end");
    s4(4'b0100, 0, 0, "post_err_rot");

    // Load clears the prescale count.
    DIV = 8'd2;
    s4(4'b0100, 0, 0, "pre_load_p1");
    LOAD = 1; LV4 = 4'b1000;
    s4(4'b1000, 0, 0, "load_legal");
    LOAD = 0;
    s4(4'b1000, 0, 0, "load_p1");
    s4(4'b1000, 0, 0, "load_p2");
    s4(4'b0001, 1, 0, "load_adv_wrap");

    // Mode switch while a ring pattern is held.
    DIV = 8'd0;
    s4(4'b0010, 0, 0, "pre_mode_1");
    s4(4'b0100, 0, 0, "pre_mode_2");
    MODE = 1;
    s4(4'b0000, 0, 1, "mode_switch_err");
    s4(4'b0001, 0, 0, "mode_switch_john");

    // WIDTH=2 and WIDTH=32 ring periods.
    RST = 1; MODE = 0; DIR = 0; DIV = 8'd0;
    push(2,  32'd1, 0, 0, "w2_rst");
    push(32, 32'd1, 0, 0, "w32_rst");
    step();
    RST = 0;
    for (int k = 1; k <= 32; k++) begin
      push(32, one32 << (k % 32), (k == 32), 0, "w32_ring");
      if (k <= 4) push(2, (k % 2 == 1) ? 32'd2 : 32'd1, (k % 2 == 0), 0, "w2_ring");
      step();
    end

    // WIDTH=32 Johnson toward LSB: 64 advances per period.
    RST = 1; MODE = 1; DIR = 1;
    push(32, 32'd0, 0, 0, "w32_john_rst");
    step();
    RST = 0;
    for (int k = 1; k <= 64; k++) begin
      if (k <= 32) push(32, ones << (32 - k), 0, 0, "w32_john_fill");
      else         push(32, ones >> (k - 32), (k == 64), 0, "w32_john_drain");
      step();
    end
    push(32, 32'h8000_0000, 0, 0, "w32_john_next");
    step();

    step();
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
